// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Reused by the CPU top level for sizing and state decoding.
package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH  = 1024;
  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned LEN_W       = 16;
  localparam int unsigned CNT_W       = IMEM_ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE
  } ldr_state_e;

  // A word count larger than the memory cannot be honoured.
  function automatic logic len_overflow(
    input logic [LEN_W-1:0] len,
    input int unsigned      depth
  );
    return 32'(len) > depth;
  endfunction

endpackage

// File: rtl/imem_loader_byte_pair.sv
// Collects a high and a low byte into one 16-bit word.
// The word only changes when the low byte lands.
module byte_pair_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] word_o
);

  logic [7:0]  hi_q;
  logic [15:0] word_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q   <= '0;
      word_q <= '0;
    end else begin
      if (hi_we_i) hi_q <= byte_i;
      if (lo_we_i) word_q <= {hi_q, byte_i};
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory
// while holding the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned CW = ADDR_W + 1;

  ldr_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              err_q, err_d;
  logic              hi_we, lo_we;
  logic              xfer;
  logic [LEN_W-1:0]  len_new;
  logic [CW-1:0]     cnt_inc;

  assign len_new = {len_q[LEN_W-1:8], in_data};
  assign cnt_inc = cnt_q + 1'b1;

  assign in_ready = (state_q == S_LEN_HI)
                 || (state_q == S_LEN_LO)
                 || (state_q == S_DATA_HI)
                 || (state_q == S_DATA_LO);
  assign xfer = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    err_d   = err_q;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN_HI;
          addr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[LEN_W-1:8] = in_data;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_new;
          if (len_new == '0) begin
            state_d = S_DONE;
          end else if (len_overflow(len_new, DEPTH)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          hi_we   = 1'b1;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          lo_we   = 1'b1;
          waddr_d = addr_q;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_inc;
        // Address may step past DEPTH-1 here but is never presented.
        if (LEN_W'(cnt_inc) == len_q) state_d = S_DONE;
        else                          state_d = S_DATA_HI;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      err_q   <= err_d;
    end
  end

  byte_pair_assembler u_bpa (
    .clock   (clock),
    .reset   (reset),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .byte_i  (in_data),
    .word_o  (mem_wdata)
  );

  assign mem_we   = (state_q == S_WRITE);
  assign mem_addr = waddr_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign cpu_hold = busy;
  assign done     = (state_q == S_DONE);
  assign error    = err_q;

endmodule
